dmem_lsu: RTL

Parametrised, handshaked data memory for the RV32I core. It adds byte, halfword and word loads and stores with sign or zero extension, and byte-lane write enables. It flags misaligned, illegal-size and out-of-range accesses, and supports a configurable number of wait states, which lets the datapath be exercised against slow memory. It sits between the execute stage (address from the ALU, funct3 from the decoder) and write-back.

---
 rtl/dmem_lsu.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/dmem_lsu.sv
// dmem_lsu: handshaked RV32I data memory with byte/half/word loads and stores,
// sign/zero extension, fault detection and a configurable number of wait states.
module dmem_lsu #(
  parameter int DEPTH       = 1024,
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        ready_q, ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0] mem_q [DEPTH];

  logic [1:0]            size_s;
  logic                  unsigned_s;
  logic                  illegal_s;
  logic                  misalign_s;
  logic                  range_err_s;
  logic                  err_s;
  logic [ADDR_WIDTH-1:0] idx_s;
  logic [1:0]            lane_s;
  logic [31:0]           rd_word_s;
  logic [7:0]            rd_byte_s;
  logic [15:0]           rd_half_s;
  logic [31:0]           load_val_s;
  logic [3:0]            be_s;
  logic [31:0]           wdata_lane_s;
  logic [3:0]            mem_wen_s;
  logic                  access_s;

  assign idx_s     = addr_q[ADDR_WIDTH+1:2];
  assign lane_s    = addr_q[1:0];
  assign rd_word_s = mem_q[idx_s];

  // Decode the latched funct3 into size (0 byte, 1 half, 2 word), signedness and legality.
  always_comb begin
    size_s     = 2'd0;
    unsigned_s = 1'b0;
    illegal_s  = 1'b0;
    case (funct3_q)
      3'b000: size_s = 2'd0;
      3'b001: size_s = 2'd1;
      3'b010: size_s = 2'd2;
      3'b100: begin
        size_s     = 2'd0;
        unsigned_s = 1'b1;
        illegal_s  = we_q;
      end
      3'b101: begin
        size_s     = 2'd1;
        unsigned_s = 1'b1;
        illegal_s  = we_q;
      end
      default: illegal_s = 1'b1;
    endcase
  end

  // Fault detection; addresses past the array never alias back onto low words.
  always_comb begin
    misalign_s  = ((size_s == 2'd1) && addr_q[0]) ||
                  ((size_s == 2'd2) && (addr_q[1:0] != 2'b00));
    range_err_s = ((addr_q >> (ADDR_WIDTH + 2)) != 32'd0);
    err_s       = illegal_s || misalign_s || range_err_s;
  end

  // Load lane selection and extension.
  always_comb begin
    case (lane_s)
      2'd0:    rd_byte_s = rd_word_s[7:0];
      2'd1:    rd_byte_s = rd_word_s[15:8];
      2'd2:    rd_byte_s = rd_word_s[23:16];
      default: rd_byte_s = rd_word_s[31:24];
    endcase
    if (lane_s[1]) begin
      rd_half_s = rd_word_s[31:16];
    end else begin
      rd_half_s = rd_word_s[15:0];
    end
    case (size_s)
      2'd0: begin
        if (unsigned_s) begin
          load_val_s = {24'd0, rd_byte_s};
        end else begin
          load_val_s = {{24{rd_byte_s[7]}}, rd_byte_s};
        end
      end
      2'd1: begin
        if (unsigned_s) begin
          load_val_s = {16'd0, rd_half_s};
        end else begin
          load_val_s = {{16{rd_half_s[15]}}, rd_half_s};
        end
      end
      default: load_val_s = rd_word_s;
    endcase
  end

  // Store byte enables and lane-replicated write data.
  always_comb begin
    case (size_s)
      2'd0: begin
        be_s         = 4'b0001 << lane_s;
        wdata_lane_s = {4{wdata_q[7:0]}};
      end
      2'd1: begin
        if (lane_s[1]) begin
          be_s = 4'b1100;
        end else begin
          be_s = 4'b0011;
        end
        wdata_lane_s = {2{wdata_q[15:0]}};
      end
      default: begin
        be_s         = 4'b1111;
        wdata_lane_s = wdata_q;
      end
    endcase
  end

  // Request/response FSM: next state, field latching and registered response values.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    funct3_d = funct3_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    access_s = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid && ready_q) begin
          we_d     = req_we;
          funct3_d = req_funct3;
          addr_d   = req_addr;
          wdata_d  = req_wdata;
          cnt_d    = 4'(WAIT_STATES);
          state_d  = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          access_s = 1'b1;
          state_d  = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    ready_d     = (state_d == S_IDLE);
    rsp_valid_d = access_s;
    rsp_err_d   = access_s && err_s;
    rsp_rdata_d = (access_s && !err_s && !we_q) ? load_val_s : 32'd0;
    // A reset on the access edge must not let the write through.
    mem_wen_s   = (access_s && !err_s && we_q && rst_n) ? be_s : 4'b0000;
  end

  // Control and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Byte-lane writable storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_wen_s[0]) mem_q[idx_s][7:0]   <= wdata_lane_s[7:0];
    if (mem_wen_s[1]) mem_q[idx_s][15:8]  <= wdata_lane_s[15:8];
    if (mem_wen_s[2]) mem_q[idx_s][23:16] <= wdata_lane_s[23:16];
    if (mem_wen_s[3]) mem_q[idx_s][31:24] <= wdata_lane_s[31:24];
  end

  assign req_ready = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
